mem_arbiter: RTL and testbench

// - Responder end of the cache<->memory request protocol: serves the icache (read-only) and the

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: serves icache reads and dcache reads/writes on one single-port RAM with a fixed
// LAT-cycle access, a one-cycle completion handshake and I/D alternation after a D completion.
module mem_arbiter #(
  parameter int LAT   = 2,
  parameter int CNT_W = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_n;
  logic             own_d, wr, last_d;
  logic [31:0]      addr_q, wdata_q, iload_q, dload_q;
  logic [CNT_W-1:0] cnt;
  logic             d_req, owner_req, grant_d, grant_i;

  assign d_req     = dREN | dWEN;
  assign owner_req = own_d ? d_req : iREN;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      last_d  <= 1'b0;
      own_d   <= 1'b0;
      wr      <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state   <= state_n;
      iload_q <= iload;
      dload_q <= dload;
      if (grant_d || grant_i) begin
        own_d   <= grant_d;
        wr      <= grant_d & dWEN;
        addr_q  <= grant_d ? daddr : iaddr;
        wdata_q <= dstore;
        cnt     <= '0;
      end else if (state == ACCESS) begin
        // Leaves ACCESS at LAT-1 at the latest, so the counter never wraps.
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) last_d <= own_d;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && last_d)) begin
          grant_d = 1'b1;
          state_n = ACCESS;
        end else if (iREN) begin
          grant_i = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!owner_req)                     state_n = IDLE;
        else if (cnt == CNT_W'(LAT - 1))    state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Word-aligned address; the low byte-offset bits are masked off on the RAM side.
  always_comb begin
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = iload_q;
    dload     = dload_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ACCESS: begin
        ram_addr = addr_q & ~32'h3;
        ram_ren  = !wr;
      end
      DONE: begin
        ram_addr = addr_q & ~32'h3;
        if (own_d) begin
          dwait = 1'b0;
          if (wr) begin
            ram_wen   = 1'b1;
            ram_wdata = wdata_q;
          end else begin
            dload = ram_rdata;
          end
        end else begin
          iwait = 1'b0;
          iload = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: directed bench for mem_arbiter (LAT=2) with a small RAM model whose read
// data appears the cycle after ram_ren and which counts committed writes.
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ram_ren, ram_wen;
  logic [31:0] iload, dload, ram_addr, ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:4095];
  int          wen_count = 0;
  logic [31:0] last_waddr, last_wdata;
  int          wc0;

  mem_arbiter #(.LAT(2), .CNT_W(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // RAM model: preloaded while reset is low; every ram_wen edge is counted.
  always @(posedge CLK) begin
    if (!nRST) begin
      mem[12'h040] <= 32'hCAFEF00D;
      mem[12'h041] <= 32'h33334444;
      mem[12'h010] <= 32'h11112222;
    end
    if (ram_wen) begin
      if (nRST) mem[ram_addr[13:2]] <= ram_wdata;
      wen_count  <= wen_count + 1;
      last_waddr <= ram_addr;
      last_wdata <= ram_wdata;
    end
    ram_rdata <= ram_ren ? mem[ram_addr[13:2]] : 32'h0;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    CLK = 0; nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    step(); step();

    // Reset values
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_ren",   ram_ren, 0);
    check("rst_wen",   ram_wen, 0);
    check("rst_addr",  ram_addr, 0);
    nRST = 1;
    step();
    check("idle_dwait", dwait, 1);

    // D read of 0x100: completion at t0+3
    dREN = 1; daddr = 32'h100;
    check("rd_t0_dwait", dwait, 1);
    step();
    check("rd_t1_dwait", dwait, 1);
    check("rd_t1_ren",   ram_ren, 1);
    check("rd_t1_addr",  ram_addr, 32'h100);
    step();
    check("rd_t2_dwait", dwait, 1);
    step();
    check("rd_t3_dwait", dwait, 0);
    check("rd_t3_dload", dload, 32'hCAFEF00D);
    check("rd_t3_iwait", iwait, 1);
    check("rd_t3_wen",   ram_wen, 0);
    dREN = 0;
    step();
    check("rd_t4_dwait", dwait, 1);
    check("rd_t4_hold",  dload, 32'hCAFEF00D);
    check("rd_t4_ren",   ram_ren, 0);

    // D write held for 6 cycles: one pulse at c3, second write starts at c4 and is aborted
    wc0 = wen_count;
    dWEN = 1; daddr = 32'h3100; dstore = 32'h5;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("wr_c%0d_dwait", k), dwait, (k == 3) ? 0 : 1);
      check($sformatf("wr_c%0d_wen", k), ram_wen, (k == 3) ? 1 : 0);
      check($sformatf("wr_c%0d_ren", k), ram_ren, 0);
      if (k == 3) begin
        check("wr_c3_addr",  ram_addr, 32'h3100);
        check("wr_c3_wdata", ram_wdata, 32'h5);
      end
      if (k == 4) check("wr_c4_idle_addr", ram_addr, 0);
      if (k == 5) check("wr_c5_addr", ram_addr, 32'h3100);
      if (k < 5) step();
    end
    dWEN = 0;
    step();
    check("wr_abort_wen", ram_wen, 0);
    step();
    check("wr_count",     wen_count, wc0 + 1);
    check("wr_waddr",     last_waddr, 32'h3100);
    check("wr_wdata",     last_wdata, 32'h5);
    check("wr_mem",       mem[12'hC40], 32'h5);

    // Abort of a read in its first ACCESS cycle
    dREN = 1; daddr = 32'h200;
    step();
    check("ab_ren",  ram_ren, 1);
    check("ab_addr", ram_addr, 32'h200);
    dREN = 0;
    step();
    check("ab_idle_ren",  ram_ren, 0);
    check("ab_idle_addr", ram_addr, 0);
    check("ab_dwait1",    dwait, 1);
    step();
    check("ab_dwait2",    dwait, 1);
    check("ab_count",     wen_count, wc0 + 1);

    // Reset during the ACCESS of a write: nothing committed, fresh full latency afterwards
    dWEN = 1; daddr = 32'h300; dstore = 32'hDEAD;
    step();
    check("rw_acc_addr", ram_addr, 32'h300);
    nRST = 0;
    step();
    check("rw_rst_wen",   ram_wen, 0);
    check("rw_rst_dwait", dwait, 1);
    check("rw_rst_addr",  ram_addr, 0);
    check("rw_rst_count", wen_count, wc0 + 1);
    nRST = 1;
    step();
    check("rw_e3_dwait", dwait, 1);
    check("rw_e3_wen",   ram_wen, 0);
    step();
    check("rw_e4_dwait", dwait, 1);
    step();
    check("rw_e5_dwait", dwait, 0);
    check("rw_e5_wen",   ram_wen, 1);
    check("rw_e5_wdata", ram_wdata, 32'hDEAD);
    dWEN = 0;
    step();
    check("rw_count", wen_count, wc0 + 2);
    check("rw_waddr", last_waddr, 32'h300);

    // Both caches requesting continuously after reset: D,I,D,I
    nRST = 0;
    step();
    nRST = 1;
    iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h104;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("alt_c%0d_dwait", k), dwait, (k % 8 == 3) ? 0 : 1);
      check($sformatf("alt_c%0d_iwait", k), iwait, (k % 8 == 7) ? 0 : 1);
      if (k % 8 == 1) check($sformatf("alt_c%0d_addr", k), ram_addr, 32'h104);
      if (k % 8 == 5) check($sformatf("alt_c%0d_addr", k), ram_addr, 32'h40);
      if (k % 8 == 3) check($sformatf("alt_c%0d_dload", k), dload, 32'h33334444);
      if (k % 8 == 7) check($sformatf("alt_c%0d_iload", k), iload, 32'h11112222);
      if (k < 15) step();
    end
    iREN = 0; dREN = 0;
    step();

    // Unaligned D read with a same-cycle I request and last_d=0: D first
    dREN = 1; daddr = 32'h103; iREN = 1; iaddr = 32'h40;
    step();
    check("ua_f1_addr",  ram_addr, 32'h100);
    check("ua_f1_ren",   ram_ren, 1);
    check("ua_f1_iwait", iwait, 1);
    step(); step();
    check("ua_f3_dwait", dwait, 0);
    check("ua_f3_dload", dload, 32'hCAFEF00D);
    check("ua_f3_iwait", iwait, 1);
    dREN = 0;
    step();
    check("ua_f4_iwait", iwait, 1);
    check("ua_f4_dhold", dload, 32'hCAFEF00D);
    step();
    check("ua_f5_addr",  ram_addr, 32'h40);
    step(); step();
    check("ua_f7_iwait", iwait, 0);
    check("ua_f7_iload", iload, 32'h11112222);
    iREN = 0;
    step();
    check("ua_f8_iwait", iwait, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
